// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and key map for the 4x4 keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} snap_t;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  // indexed by {row, col}; entry 0 is the top-left key
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, KEY_HASH, 4'h0, KEY_STAR,
    4'hC, 4'h9,     4'h8, 4'h7,
    4'hB, 4'h6,     4'h5, 4'h4,
    4'hA, 4'h3,     4'h2, 4'h1
  };
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix pins and key-event outputs
interface keypad_scanner_if;
  logic [3:0]  i_rows;
  logic [3:0]  o_cols;
  logic [3:0]  o_key;
  logic        o_valid;
  logic        o_pressed;
  logic [15:0] o_data;
  modport master (input i_rows, output o_cols, o_key, o_valid, o_pressed, o_data);
  modport slave  (output i_rows, input o_cols, o_key, o_valid, o_pressed, o_data);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer, resets to all ones
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, debounce and key-event strobe
// KEYPAD_SHIFT_EN enables the o_data shift register of the last four keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_WIDTH     = 14,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  logic [SCAN_WIDTH-1:0] cnt, cnt_nx;
  logic [3:0] rows_sync, rows, idx, key_in, cand, cand_n, stab, stab_n, key_n;
  logic [1:0] col, col_nx;
  logic [15:0] snapshot, snap_full;
  logic dwell_end, done, valid_n;
  snap_t cls;
  state_t state, state_n;
  sync_2ff #(.WIDTH(4)) u_sync (.clk(clk), .rst(rst), .d(kp.i_rows), .q(rows_sync));
  assign rows      = ~rows_sync;
  assign cnt_nx    = cnt + 1'b1;
  assign col       = cnt[SCAN_WIDTH-1 -: 2];
  assign col_nx    = cnt_nx[SCAN_WIDTH-1 -: 2];
  assign dwell_end = &cnt[SCAN_WIDTH-3:0];
  assign done      = &cnt;
  // last column lands in the snapshot on the same cycle it is classified
  always_comb begin
    snap_full = snapshot;
    snap_full[{col, 2'b00} +: 4] = rows;
    idx = '0;
    for (int i = 0; i < 16; i++) if (snap_full[i]) idx = 4'(i);
  end
  assign cls    = snap_full == '0 ? NONE : (snap_full & (snap_full - 1'b1)) == '0 ? SINGLE : MULTI;
  assign key_in = KEY_MAP[{idx[1:0], idx[3:2]}];
  always_comb begin
    state_n = state;
    cand_n  = cand;
    stab_n  = stab;
    key_n   = kp.o_key;
    valid_n = 1'b0;
    if (done)
      case (state)
        IDLE:
          if (cls == SINGLE) begin
            cand_n  = key_in;
            stab_n  = 4'd1;
            state_n = DEB == 4'd1 ? HELD : DEBOUNCE;
            key_n   = DEB == 4'd1 ? key_in : kp.o_key;
            valid_n = DEB == 4'd1;
          end
        DEBOUNCE:
          if (cls == SINGLE && key_in == cand) begin
            stab_n  = stab + 4'd1;
            state_n = stab_n == DEB ? HELD : DEBOUNCE;
            key_n   = stab_n == DEB ? cand : kp.o_key;
            valid_n = stab_n == DEB;
          end else state_n = IDLE;
        HELD:
          if (cls == NONE) begin
            stab_n  = 4'd1;
            state_n = DEB == 4'd1 ? IDLE : RELEASE;
          end
        RELEASE:
          if (cls == NONE) begin
            stab_n  = stab + 4'd1;
            state_n = stab_n == DEB ? IDLE : RELEASE;
          end else state_n = HELD;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt          <= '0;
      snapshot     <= '0;
      state        <= IDLE;
      cand         <= '0;
      stab         <= '0;
      kp.o_cols    <= 4'b1110;
      kp.o_key     <= '0;
      kp.o_valid   <= 1'b0;
      kp.o_pressed <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      if (dwell_end) snapshot[{col, 2'b00} +: 4] <= rows;
      state        <= state_n;
      cand         <= cand_n;
      stab         <= stab_n;
      kp.o_cols    <= ~(4'b0001 << col_nx);
      kp.o_key     <= key_n;
      kp.o_valid   <= valid_n;
      kp.o_pressed <= state_n == HELD || state_n == RELEASE;
    end
`ifdef KEYPAD_SHIFT_EN
  always_ff @(posedge clk)
    if (rst) kp.o_data <= '0;
    else if (valid_n) kp.o_data <= {kp.o_data[11:0], key_n};
`else
  assign kp.o_data = 16'h0000;
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce, release and key history
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keymask = '0;
  logic [3:0] rows;
  int n_cmp = 0, n_fail = 0, vcount = 0;
  keypad_scanner_if kif ();
  keypad_scanner #(.SCAN_WIDTH(4), .DEBOUNCE_SCANS(2)) dut (.clk(clk), .rst(rst), .kp(kif));
  always #5 clk = ~clk;
  // a held key pulls its row low while its column is driven low
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keymask[r*4+c] && !kif.o_cols[c]) rows[r] = 1'b0;
  end
  assign kif.i_rows = rows;
  always @(negedge clk) if (kif.o_valid) vcount++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic sync_start();
    logic [3:0] prev;
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      prev = kif.o_cols;
      step();
      if (prev == 4'b0111 && kif.o_cols == 4'b1110) ok = 1;
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL sync_start: scan start not seen got=%b want=1", ok); end
  endtask

  task automatic wait_valid(input int max, output int lat, output bit found);
    lat = 0;
    found = 0;
    while (lat < max && !found) begin
      step();
      lat++;
      if (kif.o_valid) found = 1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    do_reset();
    n_cmp++; if (kif.o_cols !== 4'b1110) begin n_fail++; $display("FAIL reset_cols: got=%b want=1110", kif.o_cols); end
    n_cmp++; if (kif.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got=%b want=0", kif.o_valid); end
    n_cmp++; if (kif.o_key !== 4'h0) begin n_fail++; $display("FAIL reset_key: got=%h want=0", kif.o_key); end
    n_cmp++; if (kif.o_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed: got=%b want=0", kif.o_pressed); end
    n_cmp++; if (kif.o_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got=%h want=0000", kif.o_data); end
    for (int i = 0; i < 32; i++) begin
      e = 4'b0001 << ((i % 16) / 4);
      e = ~e;
      n_cmp++;
      if (kif.o_cols !== e) begin n_fail++; $display("FAIL col_seq[%0d]: got=%b want=%b", i, kif.o_cols, e); end
      step();
    end
  endtask

  task automatic test_hold_6();
    int lat, v0;
    bit found, held_ok = 1;
    sync_start();
    repeat (12) step();
    v0 = vcount;
    keymask = 16'b1 << 6;
    wait_valid(80, lat, found);
    n_cmp++; if (!found || lat < 33 || lat > 49) begin n_fail++; $display("FAIL hold6_latency: got=%0d found=%b want=33..49", lat, found); end
    n_cmp++; if (kif.o_key !== 4'h6) begin n_fail++; $display("FAIL hold6_key: got=%h want=6", kif.o_key); end
    repeat (48) begin
      step();
      if (kif.o_pressed !== 1'b1) held_ok = 0;
    end
    n_cmp++; if (!held_ok) begin n_fail++; $display("FAIL hold6_pressed: got=dropped want=held"); end
    n_cmp++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL hold6_events: got=%0d want=1", vcount - v0); end
    keymask = '0;
    repeat (60) step();
    n_cmp++; if (kif.o_pressed !== 1'b0) begin n_fail++; $display("FAIL hold6_release: got=%b want=0", kif.o_pressed); end
    n_cmp++; if (kif.o_key !== 4'h6) begin n_fail++; $display("FAIL hold6_key_kept: got=%h want=6", kif.o_key); end
  endtask

  task automatic test_bounce_5();
    int v0 = vcount;
    sync_start();
    keymask = 16'b1 << 5;
    repeat (16) step();
    keymask = '0;
    repeat (64) step();
    n_cmp++; if (vcount !== v0) begin n_fail++; $display("FAIL bounce5_events: got=%0d want=0", vcount - v0); end
    n_cmp++; if (kif.o_pressed !== 1'b0) begin n_fail++; $display("FAIL bounce5_pressed: got=%b want=0", kif.o_pressed); end
  endtask

  task automatic test_multi();
    int v0 = vcount, lat;
    bit found;
    keymask = (16'b1 << 0) | (16'b1 << 10);
    repeat (80) step();
    n_cmp++; if (vcount !== v0) begin n_fail++; $display("FAIL multi19_events: got=%0d want=0", vcount - v0); end
    n_cmp++; if (kif.o_pressed !== 1'b0) begin n_fail++; $display("FAIL multi19_pressed: got=%b want=0", kif.o_pressed); end
    keymask = '0;
    repeat (40) step();
    keymask = 16'b1 << 15;
    wait_valid(80, lat, found);
    n_cmp++; if (!found || kif.o_key !== 4'hD) begin n_fail++; $display("FAIL multiD_key: got=%h found=%b want=d", kif.o_key, found); end
    keymask = keymask | (16'b1 << 1);
    repeat (80) step();
    n_cmp++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL multiD2_events: got=%0d want=1", vcount - v0); end
    n_cmp++; if (kif.o_pressed !== 1'b1 || kif.o_key !== 4'hD) begin n_fail++; $display("FAIL multiD2_hold: got=%b/%h want=1/d", kif.o_pressed, kif.o_key); end
    keymask = '0;
    repeat (60) step();
    n_cmp++; if (kif.o_pressed !== 1'b0) begin n_fail++; $display("FAIL multi_release: got=%b want=0", kif.o_pressed); end
  endtask

  task automatic test_release_glitch();
    int v0 = vcount, lat;
    bit found, drop = 0;
    keymask = 16'b1 << 6;
    wait_valid(80, lat, found);
    n_cmp++; if (!found || kif.o_key !== 4'h6) begin n_fail++; $display("FAIL glitch_press: got=%h found=%b want=6", kif.o_key, found); end
    repeat (20) step();
    sync_start();
    keymask = '0;
    repeat (16) begin step(); if (!kif.o_pressed) drop = 1; end
    keymask = 16'b1 << 6;
    repeat (48) begin step(); if (!kif.o_pressed) drop = 1; end
    n_cmp++; if (drop) begin n_fail++; $display("FAIL glitch_pressed: got=dropped want=held"); end
    n_cmp++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL glitch_events: got=%0d want=1", vcount - v0); end
    keymask = '0;
    repeat (60) step();
    n_cmp++; if (kif.o_pressed !== 1'b0) begin n_fail++; $display("FAIL clean_release: got=%b want=0", kif.o_pressed); end
    keymask = 16'b1 << 12;
    wait_valid(80, lat, found);
    n_cmp++; if (!found || kif.o_key !== 4'hE) begin n_fail++; $display("FAIL star_key: got=%h found=%b want=e", kif.o_key, found); end
    keymask = '0;
    repeat (60) step();
  endtask

  task automatic test_shift_and_reset();
    int lat, v0;
    bit found;
    int bits [4] = '{0, 1, 2, 3};
    logic [3:0] keys [4] = '{4'h1, 4'h2, 4'h3, 4'hA};
    logic [15:0] exp_data;
`ifdef KEYPAD_SHIFT_EN
    exp_data = 16'h123A;
`else
    exp_data = 16'h0000;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      keymask = 16'b1 << bits[k];
      wait_valid(80, lat, found);
      n_cmp++; if (!found || kif.o_key !== keys[k]) begin n_fail++; $display("FAIL shift_key[%0d]: got=%h found=%b want=%h", k, kif.o_key, found, keys[k]); end
      keymask = '0;
      repeat (60) step();
    end
    n_cmp++; if (kif.o_data !== exp_data) begin n_fail++; $display("FAIL shift_data: got=%h want=%h", kif.o_data, exp_data); end
    sync_start();
    keymask = 16'b1 << 5;
    repeat (20) step();
    rst = 1'b1;
    keymask = '0;
    step();
    rst = 1'b0;
    v0 = vcount;
    n_cmp++; if (kif.o_cols !== 4'b1110) begin n_fail++; $display("FAIL midrst_cols: got=%b want=1110", kif.o_cols); end
    n_cmp++; if (kif.o_data !== 16'h0 || kif.o_key !== 4'h0) begin n_fail++; $display("FAIL midrst_data: got=%h/%h want=0000/0", kif.o_data, kif.o_key); end
    repeat (64) step();
    n_cmp++; if (vcount !== v0 || kif.o_pressed !== 1'b0) begin n_fail++; $display("FAIL midrst_strobe: got=%0d/%b want=0/0", vcount - v0, kif.o_pressed); end
  endtask

  initial begin
    test_reset();
    test_hold_6();
    test_bounce_5();
    test_multi();
    test_release_glitch();
    test_shift_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving columns one at a time (active-low) and reading the rows.
- Debounces the scan result and reports each keypress as a 4-bit hex code with a one-cycle valid strobe.
- Input-side counterpart of the multiplexed hex display; o_key/o_data feed display or control logic directly.

Parameters:
- SCAN_WIDTH, 14, scan counter width; scan period = 2^SCAN_WIDTH cycles; column dwell = 2^(SCAN_WIDTH-2) cycles; legal range >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan snapshots required to accept a press or a release; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- i_rows  in  4  keypad rows, active-low, externally pulled up, asynchronous
- o_cols  out  4  column drive, active-low one-hot
- o_key  out  4  hex code of last accepted key
- o_valid  out  1  one-cycle strobe, new key accepted
- o_pressed  out  1  high while an accepted key is held
- o_data  out  16  last four keys, newest in [3:0] (see Optional Feature)

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: cnt=0, o_cols=4'b1110, o_key=0, o_valid=0, o_pressed=0, o_data=0, state=IDLE, synchronizer=4'b1111, snapshot=0.
- i_rows passes through a 2-flop synchronizer (inverted internally to active-high).
- cnt increments every cycle and wraps. col = cnt[SCAN_WIDTH-1:SCAN_WIDTH-2]. o_cols = ~(1<<col), registered.
- Row sampling: on the last cycle of each dwell (low SCAN_WIDTH-2 bits all ones), the synchronized rows are written into snapshot bits [col*4 +: 4].
- The snapshot is complete when cnt is all ones; it is classified on that cycle as NONE, SINGLE(k), or MULTI.
- Key map: row r (0 = top), column c (0 = left). Layout:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E(*) 0 F(#) D
- FSM, evaluated only at snapshot completion:
  - IDLE: SINGLE(k) -> DEBOUNCE with cand=k, stab=1; otherwise stay in IDLE.
  - DEBOUNCE: SINGLE(cand) -> stab+1. When stab reaches DEBOUNCE_SCANS -> HELD, o_key=cand, o_valid=1 for exactly the next cycle, o_pressed=1. NONE, MULTI, or a different key -> IDLE.
  - HELD: NONE -> RELEASE with stab=1. SINGLE or MULTI -> stay in HELD; no new events, no rollover.
  - RELEASE: NONE -> stab+1; when stab reaches DEBOUNCE_SCANS -> IDLE, o_pressed=0. Any pressed key -> HELD.
- DEBOUNCE_SCANS=1: the first SINGLE goes straight from IDLE to HELD with a strobe, bypassing DEBOUNCE.
- o_valid is asserted one cycle after the completing snapshot. Press latency: DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 scan periods, plus 1 cycle.
- o_key holds its value until the next accepted key.
- rst mid-scan: all state returns to reset values on the next edge; no strobe is emitted.

Optional Feature:
- Macro: KEYPAD_SHIFT_EN.
- Defined: on each o_valid, o_data <= {o_data[11:0], key}, updated in the same cycle as o_valid.
- Undefined: o_data is tied to 16'h0000 and the shift register is not synthesized.

Decomposition:
- Package keypad_pkg holds:
  - state enum (IDLE, DEBOUNCE, HELD, RELEASE)
  - snapshot class enum (NONE, SINGLE, MULTI)
  - 16-entry key-map constant indexed by {row, col}
  - KEY_STAR=4'hE, KEY_HASH=4'hF
- One sub-module: sync_2ff (parameterized width, reset value 1) for the row synchronizer.
- Scanning, classification and FSM stay in keypad_scanner.

Test Plan (SCAN_WIDTH=4, DEBOUNCE_SCANS=2; keypad model pulls row r low when pressed key's column is driven low):
- Reset -> o_cols=1110, o_valid=0, o_key=0, o_pressed=0; o_cols sequence 1110,1101,1011,0111 with 4-cycle dwells, 16-cycle period.
- Hold key '6' (row1,col2) steady -> exactly one o_valid with o_key=4'h6, 33 to 49 cycles after press; o_pressed stays 1 while held.
- Press '5' for a single scan only (bounce) -> no o_valid; state returns to IDLE.
- Hold '1' and '9' together from IDLE -> no o_valid. Hold 'D' then add '2' -> one event (4'hD) only.
- Release after HELD with one-scan glitch re-press -> o_pressed stays 1. Clean release of 2 scans -> o_pressed=0; a subsequent press of '*' yields o_key=4'hE.
- KEYPAD_SHIFT_EN defined; keys 1,2,3,A in sequence -> o_data=16'h123A. Assert rst mid-DEBOUNCE -> no strobe, o_data=0.
